// File: rtl/mem_arbiter_if.sv
// Bus bundle between the IF/MEM pipeline stages, the arbiter and the byte-wide RAM.
// The slave modport is the arbiter's view; the master modport is the view of the
// requesters plus RAM that surround it.
interface mem_arbiter_if #(
  parameter int ADDR_W = 17
);
  // Instruction fetch port
  logic              if_req_i;
  logic [31:0]       if_addr_i;
  logic              if_done_o;
  logic [31:0]       if_data_o;
  // MEM stage port
  logic              mem_req_i;
  logic              mem_we_i;
  logic [1:0]        mem_len_i;
  logic [31:0]       mem_addr_i;
  logic [31:0]       mem_wdata_i;
  logic              mem_done_o;
  logic [31:0]       mem_rdata_o;
  // RAM port
  logic [ADDR_W-1:0] ram_addr_o;
  logic              ram_we_o;
  logic [7:0]        ram_dout_o;
  logic [7:0]        ram_din_i;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_done_o, if_data_o,
    input  mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i,
    output mem_done_o, mem_rdata_o,
    output ram_addr_o, ram_we_o, ram_dout_o,
    input  ram_din_i
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_done_o, if_data_o,
    output mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i,
    input  mem_done_o, mem_rdata_o,
    input  ram_addr_o, ram_we_o, ram_dout_o,
    output ram_din_i
  );
endinterface

// File: rtl/mem_arbiter.sv
// Byte-wide RAM port arbiter for instruction fetch and the MEM stage.
// Each access is serialised into consecutive byte cycles; reads are reassembled
// little-endian and zero-extended. MEM has priority, nothing is preempted, and one
// idle cycle always follows a completed transaction.
module mem_arbiter #(
  parameter int ADDR_W = 17
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

  state_t            state_q;
  logic [2:0]        cnt_q;        // byte cycle index within the transaction
  logic [1:0]        last_q;       // byte count minus one
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       wdata_q;
  logic [31:0]       buf_q;        // bytes captured so far on a read
  logic              if_done_q;
  logic              mem_done_q;
  logic [31:0]       if_data_q;
  logic [31:0]       mem_rdata_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic              ram_we_q;
  logic [7:0]        ram_dout_q;

  logic [ADDR_W-1:0] addr_nxt_d;
  logic [1:0]        nxt_idx_d;
  logic [1:0]        cap_idx_d;
  logic [31:0]       rd_word_d;
  logic              rd_done_d;

  // Next byte address/index and the read word with the byte arriving this cycle merged in
  always_comb begin
    addr_nxt_d = base_q + ADDR_W'(cnt_q) + ADDR_W'(1);
    nxt_idx_d  = cnt_q[1:0] + 2'd1;
    // RAM data lags its address by one cycle, so cycle cnt delivers byte cnt-1
    cap_idx_d  = cnt_q[1:0] - 2'd1;
    rd_word_d  = buf_q;
    rd_word_d[{cap_idx_d, 3'b000} +: 8] = bus.ram_din_i;
    rd_done_d  = (cnt_q == ({1'b0, last_q} + 3'd1));
  end

  // Transaction sequencer with registered RAM-side and requester-side outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      last_q      <= 2'd0;
      base_q      <= '0;
      wdata_q     <= 32'd0;
      buf_q       <= 32'd0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_data_q   <= 32'd0;
      mem_rdata_q <= 32'd0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_dout_q  <= 8'd0;
    end else begin
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          ram_we_q   <= 1'b0;
          ram_addr_q <= '0;
          ram_dout_q <= 8'd0;
          // The cycle carrying a done pulse never accepts, giving the requester
          // time to drop or change its request
          if (!if_done_q && !mem_done_q) begin
            if (bus.mem_req_i) begin
              base_q     <= bus.mem_addr_i[ADDR_W-1:0];
              last_q     <= bus.mem_len_i;
              wdata_q    <= bus.mem_wdata_i;
              cnt_q      <= 3'd0;
              buf_q      <= 32'd0;
              ram_addr_q <= bus.mem_addr_i[ADDR_W-1:0];
              if (bus.mem_we_i) begin
                state_q    <= MEM_WR;
                ram_we_q   <= 1'b1;
                ram_dout_q <= bus.mem_wdata_i[7:0];
              end else begin
                state_q <= MEM_RD;
              end
            end else if (bus.if_req_i) begin
              base_q     <= bus.if_addr_i[ADDR_W-1:0];
              last_q     <= 2'd3;
              cnt_q      <= 3'd0;
              buf_q      <= 32'd0;
              ram_addr_q <= bus.if_addr_i[ADDR_W-1:0];
              state_q    <= IF_RD;
            end
          end
        end
        IF_RD, MEM_RD: begin
          if (rd_done_d) begin
            if (state_q == IF_RD) begin
              if_data_q <= rd_word_d;
              if_done_q <= 1'b1;
            end else begin
              mem_rdata_q <= rd_word_d;
              mem_done_q  <= 1'b1;
            end
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            ram_addr_q <= '0;
          end else begin
            if (cnt_q != 3'd0) buf_q <= rd_word_d;
            cnt_q <= cnt_q + 3'd1;
            // After the last address is issued it is held for the final capture cycle
            if (cnt_q[1:0] != last_q) ram_addr_q <= addr_nxt_d;
          end
        end
        MEM_WR: begin
          if (cnt_q[1:0] == last_q) begin
            mem_done_q <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_dout_q <= 8'd0;
          end else begin
            cnt_q      <= cnt_q + 3'd1;
            ram_addr_q <= addr_nxt_d;
            ram_dout_q <= wdata_q[{nxt_idx_d, 3'b000} +: 8];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.if_done_o   = if_done_q;
  assign bus.if_data_o   = if_data_q;
  assign bus.mem_done_o  = mem_done_q;
  assign bus.mem_rdata_o = mem_rdata_q;
  assign bus.ram_addr_o  = ram_addr_q;
  assign bus.ram_we_o    = ram_we_q;
  assign bus.ram_dout_o  = ram_dout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a byte RAM model with one-cycle read latency, a
// reference copy of memory updated at transaction level, directed scenarios and
// randomized transactions.
module tb_mem_arbiter;
  localparam int AW = 17;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW)) bus();
  mem_arbiter #(.ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0]  ram     [0:(1<<AW)-1];
  logic [7:0]  ref_mem [0:(1<<AW)-1];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_if_data  = 32'd0;
  logic [31:0] exp_mem_rdata = 32'd0;

  // RAM: write strobe takes effect at the edge, read data appears one cycle after the address
  always @(posedge clk) begin
    if (bus.ram_we_o) ram[bus.ram_addr_o] = bus.ram_dout_o;
    bus.ram_din_i <= ram[bus.ram_addr_o];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Little-endian word of n bytes from the reference memory, wrapping the address
  function automatic logic [31:0] model_read(input logic [16:0] a, input int n);
    logic [31:0] v;
    logic [16:0] ea;
    v = 32'd0;
    for (int k = 0; k < n; k++) begin
      ea = a + 17'(k);
      v  = v | (32'(ref_mem[ea]) << (8 * k));
    end
    return v;
  endfunction

  task automatic wait_done(input bit is_if, input int limit, output int cyc);
    logic d;
    cyc = 0;
    d   = 1'b0;
    while (!d && cyc < limit) begin
      @(negedge clk);
      cyc++;
      d = is_if ? bus.if_done_o : bus.mem_done_o;
    end
  endtask

  // One isolated transaction: checks the RAM cycle trace, done latency and result
  task automatic run_txn(input bit is_if, input bit we, input logic [1:0] len,
                         input logic [16:0] addr, input logic [31:0] wd);
    int          n, cyc, exp_done, k;
    logic [16:0] ea;
    logic [14:0] hi;
    logic        done, other;
    n        = is_if ? 4 : int'(len) + 1;
    exp_done = (!is_if && we) ? n + 1 : n + 2;
    hi       = 15'($urandom);
    @(negedge clk);
    check("idle_done", {30'd0, bus.if_done_o, bus.mem_done_o}, 32'd0);
    if (is_if) begin
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = {hi, addr};
    end else begin
      bus.mem_req_i   = 1'b1;
      bus.mem_we_i    = we;
      bus.mem_len_i   = len;
      bus.mem_addr_i  = {hi, addr};
      bus.mem_wdata_i = wd;
    end
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      done  = is_if ? bus.if_done_o : bus.mem_done_o;
      other = is_if ? bus.mem_done_o : bus.if_done_o;
      check("other_done", 32'(other), 32'd0);
      if (cyc < exp_done) begin
        k = cyc - 1;
        if (!is_if && we) begin
          ea = addr + 17'(k);
          check("wr_we", 32'(bus.ram_we_o), 32'd1);
          check("wr_byte", 32'(bus.ram_dout_o), (wd >> (8 * k)) & 32'hFF);
        end else begin
          ea = addr + 17'((k < n) ? k : n - 1);
          check("rd_we", 32'(bus.ram_we_o), 32'd0);
        end
        check("ram_addr", 32'(bus.ram_addr_o), 32'(ea));
      end
    end
    check("done_cycle", cyc, exp_done);
    check("done_we", 32'(bus.ram_we_o), 32'd0);
    check("done_addr", 32'(bus.ram_addr_o), 32'd0);
    bus.if_req_i  = 1'b0;
    bus.mem_req_i = 1'b0;
    if (!is_if && we) begin
      for (int j = 0; j < n; j++) begin
        ea = addr + 17'(j);
        ref_mem[ea] = wd[8*j +: 8];
        check("ram_byte", 32'(ram[ea]), 32'(ref_mem[ea]));
      end
    end else if (is_if) begin
      exp_if_data = model_read(addr, n);
    end else begin
      exp_mem_rdata = model_read(addr, n);
    end
    check("if_data", bus.if_data_o, exp_if_data);
    check("mem_rdata", bus.mem_rdata_o, exp_mem_rdata);
  endtask

  initial begin
    int          cyc;
    logic [16:0] ra;
    logic [31:0] dw;
    bus.if_req_i    = 1'b0;
    bus.if_addr_i   = 32'd0;
    bus.mem_req_i   = 1'b0;
    bus.mem_we_i    = 1'b0;
    bus.mem_len_i   = 2'd0;
    bus.mem_addr_i  = 32'd0;
    bus.mem_wdata_i = 32'd0;
    rst = 1'b1;
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]     = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    repeat (3) @(negedge clk);
    check("rst_if_done", 32'(bus.if_done_o), 32'd0);
    check("rst_mem_done", 32'(bus.mem_done_o), 32'd0);
    check("rst_if_data", bus.if_data_o, 32'd0);
    check("rst_mem_rdata", bus.mem_rdata_o, 32'd0);
    check("rst_ram_addr", 32'(bus.ram_addr_o), 32'd0);
    check("rst_ram_we", 32'(bus.ram_we_o), 32'd0);
    check("rst_ram_dout", 32'(bus.ram_dout_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ram_we", 32'(bus.ram_we_o), 32'd0);

    // Instruction fetch of a known word
    ram[17'h10] = 8'h13; ram[17'h11] = 8'h05; ram[17'h12] = 8'h10; ram[17'h13] = 8'h00;
    for (int i = 16; i < 20; i++) ref_mem[i] = ram[i];
    run_txn(1'b1, 1'b0, 2'd3, 17'h10, 32'd0);
    check("t1_if_data", bus.if_data_o, 32'h00100513);

    // Simultaneous requests: MEM write goes first, IF follows after the idle cycle
    @(negedge clk);
    bus.if_req_i    = 1'b1;
    bus.if_addr_i   = 32'h10;
    bus.mem_req_i   = 1'b1;
    bus.mem_we_i    = 1'b1;
    bus.mem_len_i   = 2'd3;
    bus.mem_addr_i  = 32'h100;
    bus.mem_wdata_i = 32'hDEADBEEF;
    dw = 32'hDEADBEEF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t2_we", 32'(bus.ram_we_o), 32'd1);
      check("t2_addr", 32'(bus.ram_addr_o), 32'h100 + 32'(k));
      check("t2_byte", 32'(bus.ram_dout_o), (dw >> (8 * k)) & 32'hFF);
      check("t2_if_done_early", 32'(bus.if_done_o), 32'd0);
    end
    @(negedge clk);
    check("t2_mem_done", 32'(bus.mem_done_o), 32'd1);
    bus.mem_req_i = 1'b0;
    @(negedge clk);
    check("t2_dead_addr", 32'(bus.ram_addr_o), 32'd0);
    check("t2_dead_done", {30'd0, bus.if_done_o, bus.mem_done_o}, 32'd0);
    @(negedge clk);
    check("t2_if_start", 32'(bus.ram_addr_o), 32'h10);
    wait_done(1'b1, 10, cyc);
    check("t2_if_latency", cyc, 5);
    check("t2_if_data", bus.if_data_o, 32'h00100513);
    bus.if_req_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ref_mem[17'h100 + 17'(k)] = dw[8*k +: 8];
      check("t2_ram", 32'(ram[17'h100 + 17'(k)]), 32'(dw[8*k +: 8]));
    end

    // Byte and half reads at the top of the address space
    ram[17'h1FFFF] = 8'h80; ref_mem[17'h1FFFF] = 8'h80;
    run_txn(1'b0, 1'b0, 2'd0, 17'h1FFFF, 32'd0);
    check("t3_byte", bus.mem_rdata_o, 32'h00000080);
    run_txn(1'b0, 1'b0, 2'd1, 17'h1FFFF, 32'd0);
    check("t3_half", bus.mem_rdata_o, {16'd0, ref_mem[17'h00000], 8'h80});

    // MEM request arriving mid-fetch waits for the fetch to finish
    @(negedge clk);
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h40;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 2) begin
        bus.mem_req_i  = 1'b1;
        bus.mem_we_i   = 1'b0;
        bus.mem_len_i  = 2'd1;
        bus.mem_addr_i = 32'h50;
      end
      if (c < 6) begin
        check("t4_addr", 32'(bus.ram_addr_o), 32'h40 + 32'((c - 1 < 3) ? c - 1 : 3));
        check("t4_if_done", 32'(bus.if_done_o), 32'd0);
      end else begin
        check("t4_if_done", 32'(bus.if_done_o), 32'd1);
        check("t4_mem_done", 32'(bus.mem_done_o), 32'd0);
        exp_if_data = model_read(17'h40, 4);
        check("t4_if_data", bus.if_data_o, exp_if_data);
        bus.if_req_i = 1'b0;
      end
    end
    wait_done(1'b0, 10, cyc);
    check("t4_mem_latency", cyc, 5);
    exp_mem_rdata = model_read(17'h50, 2);
    check("t4_mem_rdata", bus.mem_rdata_o, exp_mem_rdata);
    bus.mem_req_i = 1'b0;

    // Reset during the second byte of a word write, then re-issue
    @(negedge clk);
    bus.mem_req_i   = 1'b1;
    bus.mem_we_i    = 1'b1;
    bus.mem_len_i   = 2'd3;
    bus.mem_addr_i  = 32'h200;
    bus.mem_wdata_i = 32'h11223344;
    @(negedge clk);
    check("t5_b0_addr", 32'(bus.ram_addr_o), 32'h200);
    @(negedge clk);
    check("t5_b1_addr", 32'(bus.ram_addr_o), 32'h201);
    check("t5_b1_we", 32'(bus.ram_we_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_we", 32'(bus.ram_we_o), 32'd0);
    check("t5_rst_addr", 32'(bus.ram_addr_o), 32'd0);
    check("t5_rst_done", 32'(bus.mem_done_o), 32'd0);
    rst = 1'b0;
    bus.mem_req_i = 1'b0;
    exp_if_data   = 32'd0;
    exp_mem_rdata = 32'd0;
    check("t5_rst_if_data", bus.if_data_o, exp_if_data);
    check("t5_rst_mem_rdata", bus.mem_rdata_o, exp_mem_rdata);
    @(negedge clk);
    check("t5_no_late_done", 32'(bus.mem_done_o), 32'd0);
    run_txn(1'b0, 1'b1, 2'd3, 17'h200, 32'h11223344);

    // Back-to-back fetches with the request held high
    @(negedge clk);
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h10;
    wait_done(1'b1, 10, cyc);
    check("t6_first", cyc, 6);
    for (int r = 0; r < 2; r++) begin
      wait_done(1'b1, 12, cyc);
      check("t6_spacing", cyc, 7);
      check("t6_data", bus.if_data_o, 32'h00100513);
    end
    bus.if_req_i = 1'b0;
    exp_if_data  = 32'h00100513;

    // Randomized isolated transactions
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) ra = 17'h1FFFC + 17'($urandom_range(0, 3));
      else ra = 17'h300 + 17'($urandom_range(0, 255));
      run_txn(($urandom_range(0, 2) == 0), 1'($urandom), 2'($urandom), ra, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
